// File: rtl/isq_pkg.sv
// Shared issue-queue definitions: entry field layout and
// instruction age comparison.
package isq_pkg;

  localparam int ID_WIDTH   = 7;
  localparam int PREG_WIDTH = 6;
  localparam int DATA_WIDTH = 248;

  localparam int ID_LSB       = 241;
  localparam int PRS1_LSB     = 111;
  localparam int PRS2_LSB     = 105;
  localparam int SRC1_REG_BIT = 104;
  localparam int SRC2_REG_BIT = 103;

  // MSB is a wrap bit: differing wrap bits invert the plain compare
  function automatic logic is_younger(
    input logic [ID_WIDTH-1:0] flush_id,
    input logic [ID_WIDTH-1:0] id
  );
    return (flush_id[ID_WIDTH-1] ^ id[ID_WIDTH-1]) ^
           (flush_id[ID_WIDTH-2:0] < id[ID_WIDTH-2:0]);
  endfunction

endpackage

// File: rtl/isq_issue_arbiter_rr.sv
// Round-robin pick: first eligible requester at or after the
// pointer. Pointer state lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_REQ_LOG = 1
) (
  input  logic [NUM_REQ-1:0]     i_eligible,
  input  logic [NUM_REQ_LOG-1:0] i_rr_ptr,
  input  logic                   i_enable,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ_LOG-1:0] o_grant_idx,
  output logic                   o_any
);

  int                   w_j;
  logic [NUM_REQ_LOG-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_j         = 0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j   = (int'(i_rr_ptr) + k) % NUM_REQ;
      w_idx = NUM_REQ_LOG'(w_j);
      if (i_enable && !o_any && i_eligible[w_idx]) begin
        o_any          = 1'b1;
        o_grant_idx    = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/isq_issue_arbiter.sv
// Issue arbiter: shares one PRF read pair and one FU slot
// between issue queues, with a single registered output stage.
module isq_issue_arbiter
  import isq_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int NUM_REQ_LOG = 1
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          prf_rs1_rden,
  output logic [PREG_WIDTH-1:0]         prf_rs1_rdaddr,
  input  logic [63:0]                   prf_rs1_rddata,
  output logic                          prf_rs2_rden,
  output logic [PREG_WIDTH-1:0]         prf_rs2_rdaddr,
  input  logic [63:0]                   prf_rs2_rddata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [63:0]                   out_src1,
  output logic [63:0]                   out_src2,
  output logic [NUM_REQ_LOG-1:0]        out_req_id,
  input  logic                          flush_valid,
  input  logic [ID_WIDTH-1:0]           flush_id
);

  logic [NUM_REQ_LOG-1:0] r_rr_ptr;
  logic [DATA_WIDTH-1:0]  w_ent [NUM_REQ];
  logic [NUM_REQ-1:0]     w_elig;
  logic [NUM_REQ-1:0]     w_grant;
  logic [NUM_REQ_LOG-1:0] w_idx;
  logic [NUM_REQ_LOG-1:0] w_ptr_nxt;
  logic [DATA_WIDTH-1:0]  w_sel;
  logic                   w_any;
  logic                   w_killed;
  logic                   w_can_accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_ent[g]  = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_elig[g] = req_valid[g] && !(flush_valid &&
      is_younger(flush_id, w_ent[g][ID_LSB +: ID_WIDTH]));
  end

  assign w_killed = out_valid && flush_valid &&
    is_younger(flush_id, out_data[ID_LSB +: ID_WIDTH]);
  assign w_can_accept = !out_valid || out_ready || w_killed;

  rr_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .NUM_REQ_LOG (NUM_REQ_LOG)
  ) u_rr (
    .i_eligible  (w_elig),
    .i_rr_ptr    (r_rr_ptr),
    .i_enable    (w_can_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx),
    .o_any       (w_any)
  );

  assign req_ready = w_grant;
  assign w_sel     = w_ent[w_idx];
  assign w_ptr_nxt = (int'(w_idx) == NUM_REQ - 1) ?
                     '0 : w_idx + 1'b1;

  assign prf_rs1_rden   = w_any && w_sel[SRC1_REG_BIT];
  assign prf_rs2_rden   = w_any && w_sel[SRC2_REG_BIT];
  assign prf_rs1_rdaddr = prf_rs1_rden ?
                          w_sel[PRS1_LSB +: PREG_WIDTH] : '0;
  assign prf_rs2_rdaddr = prf_rs2_rden ?
                          w_sel[PRS2_LSB +: PREG_WIDTH] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src1   <= '0;
      out_src2   <= '0;
      out_req_id <= '0;
    end else if (w_any) begin
      r_rr_ptr   <= w_ptr_nxt;
      out_valid  <= 1'b1;
      out_data   <= w_sel;
      out_src1   <= w_sel[SRC1_REG_BIT] ? prf_rs1_rddata : '0;
      out_src2   <= w_sel[SRC2_REG_BIT] ? prf_rs2_rddata : '0;
      out_req_id <= w_idx;
    end else if (w_can_accept) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isq_issue_arbiter.sv
// Directed bench for isq_issue_arbiter: round robin, operand
// capture, stall, flush by age and asynchronous reset.
module tb_isq_issue_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [495:0] req_data;
  logic         prf_rs1_rden;
  logic [5:0]   prf_rs1_rdaddr;
  logic [63:0]  prf_rs1_rddata;
  logic         prf_rs2_rden;
  logic [5:0]   prf_rs2_rdaddr;
  logic [63:0]  prf_rs2_rddata;
  logic         out_valid;
  logic         out_ready;
  logic [247:0] out_data;
  logic [63:0]  out_src1;
  logic [63:0]  out_src2;
  logic [0:0]   out_req_id;
  logic         flush_valid;
  logic [6:0]   flush_id;

  int total = 0;
  int bad   = 0;

  isq_issue_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .prf_rs1_rden   (prf_rs1_rden),
    .prf_rs1_rdaddr (prf_rs1_rdaddr),
    .prf_rs1_rddata (prf_rs1_rddata),
    .prf_rs2_rden   (prf_rs2_rden),
    .prf_rs2_rdaddr (prf_rs2_rdaddr),
    .prf_rs2_rddata (prf_rs2_rddata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_src1       (out_src1),
    .out_src2       (out_src2),
    .out_req_id     (out_req_id),
    .flush_valid    (flush_valid),
    .flush_id       (flush_id)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [247:0] mk(
    input logic [6:0]  id,
    input logic [5:0]  p1,
    input logic [5:0]  p2,
    input logic        r1,
    input logic        r2,
    input logic [31:0] tag
  );
    logic [247:0] e;
    e = '0;
    e[247:241] = id;
    e[116:111] = p1;
    e[110:105] = p2;
    e[104]     = r1;
    e[103]     = r2;
    e[31:0]    = tag;
    return e;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    req_valid = 2'b00;
    req_data = '0;
    prf_rs1_rddata = '0;
    prf_rs2_rddata = '0;
    out_ready = 1'b0;
    flush_valid = 1'b0;
    flush_id = '0;
    @(negedge clock); #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 ||
        out_src1 !== '0 || out_src2 !== '0 || out_req_id !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got v=%b id=%b d=%h exp v=0 id=0 d=0",
               out_valid, out_req_id, out_data[31:0]);
    end
    total++;
    if (req_ready !== 2'b00 || prf_rs1_rden !== 1'b0 ||
        prf_rs2_rden !== 1'b0 || prf_rs1_rdaddr !== 6'd0) begin
      bad++;
      $display("FAIL reset_req got rdy=%b rden=%b%b exp rdy=00 rden=00",
               req_ready, prf_rs1_rden, prf_rs2_rden);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [0:0]  exp;
    logic [31:0] tag;
    @(negedge clock);
    req_data  = {mk(7'h02, 6'd0, 6'd0, 1'b0, 1'b0, 32'h200),
                 mk(7'h01, 6'd0, 6'd0, 1'b0, 1'b0, 32'h100)};
    req_valid = 2'b11;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp = 1'(c % 2);
      tag = exp ? 32'h200 : 32'h100;
      if (c != 0) @(negedge clock);
      #1;
      total++;
      if (req_ready !== (2'b01 << exp)) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b exp=%b", c, req_ready,
                 2'b01 << exp);
      end
      @(posedge clock); #1;
      total++;
      if (out_valid !== 1'b1 || out_req_id !== exp ||
          out_data[31:0] !== tag) begin
        bad++;
        $display("FAIL rr_out%0d got v=%b id=%b tag=%h exp v=1 id=%b tag=%h",
                 c, out_valid, out_req_id, out_data[31:0], exp, tag);
      end
    end
    @(negedge clock);
    req_valid = 2'b00;
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_operands();
    @(negedge clock);
    req_data[247:0] = mk(7'h04, 6'd5, 6'd9, 1'b1, 1'b1, 32'h300);
    req_valid = 2'b01;
    prf_rs1_rddata = 64'hAA;
    prf_rs2_rddata = 64'hBB;
    #1;
    total++;
    if (req_ready !== 2'b01 || prf_rs1_rden !== 1'b1 ||
        prf_rs2_rden !== 1'b1 || prf_rs1_rdaddr !== 6'd5 ||
        prf_rs2_rdaddr !== 6'd9) begin
      bad++;
      $display("FAIL op_read got rdy=%b rden=%b%b a1=%0d a2=%0d exp rdy=01 rden=11 a1=5 a2=9",
               req_ready, prf_rs1_rden, prf_rs2_rden,
               prf_rs1_rdaddr, prf_rs2_rdaddr);
    end
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b1 || out_src1 !== 64'hAA ||
        out_src2 !== 64'hBB) begin
      bad++;
      $display("FAIL op_capture got v=%b s1=%h s2=%h exp v=1 s1=aa s2=bb",
               out_valid, out_src1, out_src2);
    end
  endtask

  task automatic test_src2_imm();
    @(negedge clock);
    req_data[247:0] = mk(7'h06, 6'd7, 6'd12, 1'b1, 1'b0, 32'h301);
    req_valid = 2'b01;
    prf_rs2_rddata = 64'hCC;
    #1;
    total++;
    if (req_ready !== 2'b01 || prf_rs2_rden !== 1'b0 ||
        prf_rs2_rdaddr !== 6'd0 || prf_rs1_rden !== 1'b1 ||
        prf_rs1_rdaddr !== 6'd7) begin
      bad++;
      $display("FAIL imm_read got rdy=%b rden=%b%b a1=%0d a2=%0d exp rdy=01 rden=10 a1=7 a2=0",
               req_ready, prf_rs1_rden, prf_rs2_rden,
               prf_rs1_rdaddr, prf_rs2_rdaddr);
    end
    @(posedge clock); #1;
    total++;
    if (out_src2 !== 64'h0 || out_src1 !== 64'hAA ||
        out_data[31:0] !== 32'h301) begin
      bad++;
      $display("FAIL imm_capture got s1=%h s2=%h tag=%h exp s1=aa s2=0 tag=301",
               out_src1, out_src2, out_data[31:0]);
    end
    @(negedge clock);
    req_valid = 2'b00;
    @(posedge clock); #1;
  endtask

  task automatic test_stall();
    @(negedge clock);
    req_data  = {mk(7'h09, 6'd0, 6'd0, 1'b0, 1'b0, 32'h500),
                 mk(7'h08, 6'd0, 6'd0, 1'b0, 1'b0, 32'h400)};
    req_valid = 2'b11;
    out_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL stall_fill got=%b exp=10", req_ready);
    end
    @(posedge clock); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock); #1;
      total++;
      if (req_ready !== 2'b00 || prf_rs1_rden !== 1'b0 ||
          prf_rs2_rden !== 1'b0) begin
        bad++;
        $display("FAIL stall_rdy%0d got rdy=%b rden=%b%b exp rdy=00 rden=00",
                 c, req_ready, prf_rs1_rden, prf_rs2_rden);
      end
      @(posedge clock); #1;
      total++;
      if (out_valid !== 1'b1 || out_req_id !== 1'b1 ||
          out_data[31:0] !== 32'h500) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b id=%b tag=%h exp v=1 id=1 tag=500",
                 c, out_valid, out_req_id, out_data[31:0]);
      end
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL stall_resume got=%b exp=01", req_ready);
    end
    @(posedge clock); #1;
    total++;
    if (out_req_id !== 1'b0 || out_data[31:0] !== 32'h400) begin
      bad++;
      $display("FAIL stall_next got id=%b tag=%h exp id=0 tag=400",
               out_req_id, out_data[31:0]);
    end
    @(negedge clock);
    req_valid = 2'b00;
    @(posedge clock); #1;
  endtask

  task automatic test_flush();
    @(negedge clock);
    req_data[247:0] = mk(7'h05, 6'd0, 6'd0, 1'b0, 1'b0, 32'h600);
    req_valid = 2'b01;
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    req_valid = 2'b00;
    out_ready = 1'b0;
    flush_valid = 1'b1;
    flush_id = 7'h03;
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_kill got v=%b exp v=0", out_valid);
    end
    @(negedge clock);
    flush_valid = 1'b0;
    req_data[247:0] = mk(7'h03, 6'd0, 6'd0, 1'b0, 1'b0, 32'h601);
    req_valid = 2'b01;
    @(posedge clock); #1;
    @(negedge clock);
    req_valid = 2'b00;
    flush_valid = 1'b1;
    flush_id = 7'h03;
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b1 || out_data[247:241] !== 7'h03) begin
      bad++;
      $display("FAIL flush_keep got v=%b id=%h exp v=1 id=03",
               out_valid, out_data[247:241]);
    end
    @(negedge clock);
    flush_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_wrap_reset();
    @(negedge clock);
    req_data  = {mk(7'h10, 6'd0, 6'd0, 1'b0, 1'b0, 32'h700),
                 mk(7'h00, 6'd0, 6'd0, 1'b0, 1'b0, 32'h0)};
    req_valid = 2'b10;
    @(posedge clock); #1;
    @(negedge clock);
    req_data  = {mk(7'h7D, 6'd0, 6'd0, 1'b0, 1'b0, 32'h701),
                 mk(7'h01, 6'd0, 6'd0, 1'b0, 1'b0, 32'h702)};
    req_valid = 2'b11;
    out_ready = 1'b0;
    flush_valid = 1'b1;
    flush_id = 7'h7E;
    #1;
    total++;
    if (req_ready !== 2'b10) begin
      bad++;
      $display("FAIL wrap_grant got=%b exp=10", req_ready);
    end
    @(posedge clock); #1;
    total++;
    if (out_valid !== 1'b1 || out_req_id !== 1'b1 ||
        out_data[247:241] !== 7'h7D) begin
      bad++;
      $display("FAIL wrap_out got v=%b q=%b id=%h exp v=1 q=1 id=7d",
               out_valid, out_req_id, out_data[247:241]);
    end
    @(negedge clock);
    flush_valid = 1'b0;
    req_data[247:0] = mk(7'h11, 6'd0, 6'd0, 1'b0, 1'b0, 32'h703);
    req_valid = 2'b01;
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    req_valid = 2'b00;
    out_ready = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_req_id !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got v=%b tag=%h exp v=0 tag=0",
               out_valid, out_data[31:0]);
    end
    @(negedge clock);
    reset_n = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b01) begin
      bad++;
      $display("FAIL reset_ptr got=%b exp=01", req_ready);
    end
    @(posedge clock); #1;
    @(negedge clock);
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_operands();
    test_src2_imm();
    test_stall();
    test_flush();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isq_issue_arbiter.md
Name: isq_issue_arbiter

Overview:
- Shares one physical-register-file (PRF) read-port pair and one FU issue slot between NUM_REQ issue queues.
- Each cycle it grants at most one ready queue head, round-robin, and drives the PRF rs1/rs2 read ports for that entry.
- It registers entry plus operand data into a single output stage toward the FU.
- Flush-aware: kills younger in-flight and candidate entries by instr_id age.

Parameters:
NUM_REQ, 2, number of requesting issue queues
NUM_REQ_LOG, 1, width of requester index
DATA_WIDTH, 248, issue-queue entry width (dispatch packing)
PREG_WIDTH, 6, physical register index width
ID_WIDTH, 7, instr_id width; MSB is wrap bit

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  queue i presents a woken entry
req_ready  out  NUM_REQ  one-hot grant; entry i consumed this cycle
req_data  in  NUM_REQ*DATA_WIDTH  packed entries, queue i at [i*DATA_WIDTH +: DATA_WIDTH]
prf_rs1_rden  out  1  PRF port 1 read enable
prf_rs1_rdaddr  out  PREG_WIDTH  PRF port 1 address
prf_rs1_rddata  in  64  PRF port 1 data, same-cycle combinational
prf_rs2_rden  out  1  PRF port 2 read enable
prf_rs2_rdaddr  out  PREG_WIDTH  PRF port 2 address
prf_rs2_rddata  in  64  PRF port 2 data, same-cycle combinational
out_valid  out  1  output stage holds an instruction
out_ready  in  1  FU accepts output
out_data  out  DATA_WIDTH  registered entry
out_src1  out  64  registered operand 1
out_src2  out  64  registered operand 2
out_req_id  out  NUM_REQ_LOG  source queue of the output entry
flush_valid  in  1  redirect flush
flush_id  in  ID_WIDTH  id of the flushing instruction; it and older survive

Behaviour:
- Entry fields: id [247:241], prs1 [116:111], prs2 [110:105], src1_is_reg [104], src2_is_reg [103].
- Reset values:
  - out_valid=0, out_data/out_src1/out_src2/out_req_id=0, rr_ptr=0.
  - req_ready=0 and PRF rden=0 while out_valid=0 and no req_valid.
- younger(id) = (flush_id[MSB]^id[MSB]) ^ (flush_id[MSB-1:0] < id[MSB-1:0]). Equal ids are not younger.
- Accept condition:
  - can_accept = !out_valid || (out_valid && out_ready) || out_killed.
  - out_killed = flush_valid && younger(out_data id).
- Candidate i is eligible when req_valid[i] && !(flush_valid && younger(req id i)).
- Grant:
  - If can_accept, grant the first eligible i scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = onehot(grant). No grant means all zeros.
  - req_ready depends on req_valid and out_ready combinationally; requesters must not loop back.
- On grant:
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - prf_rsK_rden = srcK_is_reg, prf_rsK_rdaddr = prsK, both combinational in the grant cycle.
  - Next edge registers out_data=entry, out_src1 = src1_is_reg ? prf_rs1_rddata : 0 (same for src2), out_req_id=grant, out_valid=1.
  - Latency: grant at cycle N gives out_valid at N+1.
- No grant with output drained or killed: out_valid <= 0. rr_ptr holds.
- While out_valid && !out_ready and not killed:
  - Output registers are held stable.
  - req_ready=0, rden=0.
- Flush:
  - Younger output is dropped in the same cycle (out_valid<=0 unless a new grant).
  - An older output is kept and holds normally.
  - A younger candidate is never granted. rr_ptr advances only on grant.
- Simultaneous drain and grant: back-to-back, one instruction per cycle sustained.
- Reset mid-operation: all state cleared immediately. In-flight entry lost; owning queue reissues per its own reset.
- Unused PRF ports: rdaddr is driven 0 when rden=0.

Decomposition:
- Shared package isq_pkg:
  - ID_WIDTH, PREG_WIDTH, DATA_WIDTH.
  - Entry field offset constants.
  - Function is_younger(flush_id, id), reused by issue queue walk/flush logic.
- Sub-module rr_arbiter (NUM_REQ; inputs eligible, rr_ptr, enable; outputs one-hot grant, grant_idx, any). Pointer update stays in the parent.

Test Plan:
1. Both queues valid every cycle, out_ready=1 -> grants alternate q0,q1,q0,q1. One out_valid per cycle; out_req_id matches, lagging one cycle.
2. q0 entry prs1=5, prs2=9, both is_reg, PRF returns 0xAA/0xBB -> rs1 rdaddr=5, rs2 rdaddr=9, rden=1 in grant cycle. Next cycle out_src1=0xAA, out_src2=0xBB.
3. src2_is_reg=0 -> prf_rs2_rden=0, out_src2=0 regardless of rddata.
4. out_ready=0 for 3 cycles with both queues valid -> req_ready=00 and outputs stable. On out_ready=1, the next grant uses the unchanged rr_ptr.
5. Output id=0x05, flush_id=0x03 with out_ready=0 -> out_valid drops next cycle. Output id=0x03 with flush_id=0x03 -> retained.
6. Wrap age: flush_id=0x7E, q0 id=0x01 (younger, wrapped) not granted; q1 id=0x7D granted. Assert reset_n=0 mid-hold -> out_valid=0 asynchronously, rr_ptr=0.
